// File: rtl/vid_in_pkg.sv
// vid_in_pkg: shared state type and FIFO entry layout for the video-in bridge
package vid_in_pkg;
  typedef enum logic [0:0] {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;
  localparam int SOF_BIT = 1;
  localparam int LAST_BIT = 0;
  function automatic int entry_width(input int data_width);
    return data_width + 2;
  endfunction
endpackage

// File: rtl/vid_in_fifo.sv
// vid_in_fifo: synchronous first-word-fall-through FIFO with pointer-based full/empty
module vid_in_fifo #(
  parameter int WIDTH = 18,
  parameter int ADDR_BITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS:0] wr_ptr, rd_ptr;
  assign full = (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]) && (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign dout = empty ? '0 : mem[rd_ptr[ADDR_BITS-1:0]];
  // pointers advance only on accepted operations; a push into a full FIFO is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (ADDR_BITS+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (ADDR_BITS+1)'(1);
    end
  end
  // storage is not reset; the output is masked while empty
  always_ff @(posedge clk) if (push && !full) mem[wr_ptr[ADDR_BITS-1:0]] <= din;
endmodule

// File: rtl/vid_in_axi4s_bridge.sv
// vid_in_axi4s_bridge: parallel video capture into an AXI4-Stream video stream
module vid_in_axi4s_bridge
  import vid_in_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_ADDR_BITS = 5
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  vid_ce,
  input  logic                  video_de,
  input  logic                  video_vsync,
  input  logic                  video_hsync,
  input  logic [DATA_WIDTH-1:0] video_data,
  output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
  output logic                  m_axis_video_tvalid,
  input  logic                  m_axis_video_tready,
  output logic                  m_axis_video_tuser,
  output logic                  m_axis_video_tlast,
  output logic                  locked,
  output logic                  overflow,
  output logic                  empty
);
  localparam int EW = entry_width(DATA_WIDTH);
  state_t state;
  logic vs_q, vs_edge, hold_v, hold_sof, sof_pending, push, full, unused_hsync;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [EW-1:0] din, dout;
  assign unused_hsync = video_hsync;
  assign vs_edge = vid_ce && video_vsync && !vs_q;
  assign push = vid_ce && (state == ACTIVE) && hold_v;
  assign m_axis_video_tdata = dout[DATA_WIDTH-1:0];
  assign m_axis_video_tuser = dout[DATA_WIDTH+SOF_BIT];
  assign m_axis_video_tlast = dout[DATA_WIDTH+LAST_BIT];
  assign m_axis_video_tvalid = !empty;
  // held pixel is the last of its line when DE drops or a new frame starts
  always_comb begin
    din = EW'(hold_data);
    din[DATA_WIDTH+SOF_BIT] = hold_sof;
    din[DATA_WIDTH+LAST_BIT] = !video_de || vs_edge;
  end
  // vsync history for edge detection, updated only on sampled cycles
  always_ff @(posedge aclk) begin
    if (rst) vs_q <= 1'b0;
    else if (vid_ce) vs_q <= video_vsync;
  end
  // frame lock FSM, lookahead hold register and sticky overflow
  always_ff @(posedge aclk) begin
    if (rst) begin
      state <= WAIT_SOF;
      hold_v <= 1'b0;
      hold_sof <= 1'b0;
      hold_data <= '0;
      sof_pending <= 1'b0;
      overflow <= 1'b0;
      locked <= 1'b0;
    end else begin
      locked <= state == ACTIVE;
      if (push && full) begin
        overflow <= 1'b1;
        state <= WAIT_SOF;
        hold_v <= 1'b0;
        sof_pending <= 1'b0;
      end else if (vid_ce) begin
        if (state == WAIT_SOF) begin
          hold_v <= 1'b0;
          sof_pending <= vs_edge;
          state <= vs_edge ? ACTIVE : WAIT_SOF;
        end else begin
          hold_v <= video_de;
          if (video_de) begin
            hold_sof <= sof_pending || vs_edge;
            hold_data <= video_data;
          end
          sof_pending <= video_de ? 1'b0 : (sof_pending || vs_edge);
        end
      end
    end
  end
  vid_in_fifo #(.WIDTH(EW), .ADDR_BITS(FIFO_ADDR_BITS)) u_fifo (
    .clk(aclk),
    .rst(rst),
    .push(push),
    .pop(m_axis_video_tready),
    .din(din),
    .dout(dout),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_vid_in_axi4s_bridge.sv
// tb_vid_in_axi4s_bridge: directed frames checked against a frame-level beat model
module tb_vid_in_axi4s_bridge;
  localparam int DW = 16;
  typedef struct packed {logic [DW-1:0] d; logic u; logic l;} beat_t;
  logic clk = 0, rst = 1, vid_ce = 0, de = 0, vs = 0, hs = 0;
  logic [DW-1:0] vd = '0;
  logic rdy_fix = 1, rnd_rdy = 0, rnd_bit = 1, tready, tready_s = 1;
  logic [DW-1:0] tdata, tdata_s;
  logic tvalid, tuser, tlast, locked, overflow, empty;
  logic tvalid_s, tuser_s, tlast_s, locked_s, overflow_s, empty_s;
  int n_cmp = 0, n_bad = 0;
  beat_t exp_q[$], got_m[$], got_s[$];
  beat_t prev, e;
  bit synced = 0, sof_next = 0, alt_ce = 0, prev_stall = 0;

  assign tready = rnd_rdy ? rnd_bit : rdy_fix;
  always #5 clk = ~clk;

  vid_in_axi4s_bridge #(.DATA_WIDTH(DW), .FIFO_ADDR_BITS(5)) dut (
    .aclk(clk), .rst(rst), .vid_ce(vid_ce), .video_de(de), .video_vsync(vs),
    .video_hsync(hs), .video_data(vd), .m_axis_video_tdata(tdata),
    .m_axis_video_tvalid(tvalid), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser), .m_axis_video_tlast(tlast),
    .locked(locked), .overflow(overflow), .empty(empty));

  vid_in_axi4s_bridge #(.DATA_WIDTH(DW), .FIFO_ADDR_BITS(2)) dut_s (
    .aclk(clk), .rst(rst), .vid_ce(vid_ce), .video_de(de), .video_vsync(vs),
    .video_hsync(hs), .video_data(vd), .m_axis_video_tdata(tdata_s),
    .m_axis_video_tvalid(tvalid_s), .m_axis_video_tready(tready_s),
    .m_axis_video_tuser(tuser_s), .m_axis_video_tlast(tlast_s),
    .locked(locked_s), .overflow(overflow_s), .empty(empty_s));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // compare every main-stream transfer against the model; check stall stability
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk("stall_tvalid", 32'(tvalid), 1);
        chk("stall_beat", 32'({tdata, tuser, tlast}), 32'(prev));
      end
      if (tvalid && tready) begin
        got_m.push_back(beat_t'({tdata, tuser, tlast}));
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got data %0h with none pending", tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_tdata", 32'(tdata), 32'(e.d));
          chk("beat_tuser", 32'(tuser), 32'(e.u));
          chk("beat_tlast", 32'(tlast), 32'(e.l));
        end
      end
      prev_stall = tvalid && !tready;
      prev = beat_t'({tdata, tuser, tlast});
    end
  end

  always @(negedge clk) if (!rst && tvalid_s && tready_s) got_s.push_back(beat_t'({tdata_s, tuser_s, tlast_s}));

  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic vsample(input logic d_e, input logic v_s, input logic [DW-1:0] d);
    if (alt_ce) begin
      vid_ce = 0; de = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
      vd = DW'($urandom); hs = ~hs;
      cyc();
    end
    vid_ce = 1; de = d_e; vs = v_s; vd = d;
    cyc();
  endtask

  task automatic vsync_pulse();
    vsample(0, 1, '0);
    vsample(0, 1, '0);
    vsample(0, 0, '0);
    synced = 1;
    sof_next = 1;
  endtask

  task automatic line(input int n, input logic [DW-1:0] base, input bit tail);
    beat_t b;
    if (synced && tail) begin
      for (int i = 0; i < n; i++) begin
        b.d = base + DW'(i);
        b.u = sof_next && (i == 0);
        b.l = (i == n - 1);
        exp_q.push_back(b);
      end
      sof_next = 0;
    end
    for (int i = 0; i < n; i++) vsample(1, 0, base + DW'(i));
    if (tail) vsample(0, 0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) vsample(0, 0, '0);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((exp_q.size() != 0 || !empty) && t < 500) begin
      cyc();
      t++;
    end
    chk({nm, "_pending"}, 32'(exp_q.size()), 0);
    chk({nm, "_empty"}, 32'(empty), 1);
  endtask

  task automatic do_reset(input string nm);
    rst = 1;
    cyc();
    chk({nm, "_tvalid"}, 32'(tvalid), 0);
    chk({nm, "_tuser"}, 32'(tuser), 0);
    chk({nm, "_tlast"}, 32'(tlast), 0);
    chk({nm, "_tdata"}, 32'(tdata), 0);
    chk({nm, "_locked"}, 32'(locked), 0);
    chk({nm, "_overflow"}, 32'(overflow), 0);
    chk({nm, "_empty"}, 32'(empty), 1);
    chk({nm, "_s_tvalid"}, 32'(tvalid_s), 0);
    chk({nm, "_s_overflow"}, 32'(overflow_s), 0);
    exp_q.delete(); got_m.delete(); got_s.delete();
    synced = 0; sof_next = 0;
    vid_ce = 0; de = 0; vs = 0;
    cyc();
    rst = 0;
  endtask

  initial begin
    do_reset("rst1");
    vsync_pulse();
    line(4, 16'd1, 1);
    line(4, 16'd5, 1);
    idle(2);
    drain("t1");
    chk("t1_count", 32'(got_m.size()), 8);
    chk("t1_beat0", 32'(got_m[0]), 32'({16'd1, 1'b1, 1'b0}));
    chk("t1_beat1", 32'(got_m[1]), 32'({16'd2, 1'b0, 1'b0}));
    chk("t1_beat3", 32'(got_m[3]), 32'({16'd4, 1'b0, 1'b1}));
    chk("t1_beat4", 32'(got_m[4]), 32'({16'd5, 1'b0, 1'b0}));
    chk("t1_beat7", 32'(got_m[7]), 32'({16'd8, 1'b0, 1'b1}));
    chk("t1_locked", 32'(locked), 1);
    chk("t1_overflow", 32'(overflow), 0);

    do_reset("rst2");
    line(4, 16'h20, 1);
    idle(4);
    chk("t2_no_beats", 32'(got_m.size()), 0);
    chk("t2_unlocked", 32'(locked), 0);
    chk("t2_empty", 32'(empty), 1);
    vsync_pulse();
    line(3, 16'h30, 1);
    idle(2);
    drain("t2");
    chk("t2_count", 32'(got_m.size()), 3);
    chk("t2_beat0", 32'(got_m[0]), 32'({16'h30, 1'b1, 1'b0}));
    chk("t2_beat2", 32'(got_m[2]), 32'({16'h32, 1'b0, 1'b1}));

    do_reset("rst3");
    tready_s = 0;
    vsync_pulse();
    line(6, 16'h40, 1);
    idle(3);
    chk("t3_overflow", 32'(overflow_s), 1);
    chk("t3_unlocked", 32'(locked_s), 0);
    chk("t3_held", 32'(got_s.size()), 0);
    tready_s = 1;
    idle(10);
    chk("t3_count", 32'(got_s.size()), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_data", 32'(got_s[i].d), 32'(16'h40 + i));
      chk("t3_no_tlast", 32'(got_s[i].l), 0);
      chk("t3_tuser", 32'(got_s[i].u), 32'(i == 0));
    end
    vsync_pulse();
    line(2, 16'h50, 1);
    idle(4);
    chk("t3_next_count", 32'(got_s.size()), 6);
    chk("t3_next_beat0", 32'(got_s[4]), 32'({16'h50, 1'b1, 1'b0}));
    chk("t3_next_beat1", 32'(got_s[5]), 32'({16'h51, 1'b0, 1'b1}));
    chk("t3_sticky", 32'(overflow_s), 1);
    chk("t3_relocked", 32'(locked_s), 1);
    drain("t3");
    chk("t3_main_overflow", 32'(overflow), 0);

    do_reset("rst4");
    alt_ce = 1;
    rnd_rdy = 1;
    vsync_pulse();
    line(4, 16'd1, 1);
    line(4, 16'd5, 1);
    idle(2);
    drain("t4");
    rnd_rdy = 0;
    alt_ce = 0;
    chk("t4_count", 32'(got_m.size()), 8);
    chk("t4_beat0", 32'(got_m[0]), 32'({16'd1, 1'b1, 1'b0}));
    chk("t4_beat7", 32'(got_m[7]), 32'({16'd8, 1'b0, 1'b1}));

    rdy_fix = 0;
    vsync_pulse();
    line(3, 16'h60, 0);
    chk("t5_stalled_valid", 32'(tvalid), 1);
    do_reset("rst5");
    rdy_fix = 1;
    vsync_pulse();
    line(4, 16'h70, 1);
    idle(2);
    drain("t5");
    chk("t5_count", 32'(got_m.size()), 4);
    chk("t5_beat0", 32'(got_m[0]), 32'({16'h70, 1'b1, 1'b0}));

    vsync_pulse();
    line(1, 16'h80, 1);
    idle(2);
    drain("t6");
    chk("t6_count", 32'(got_m.size()), 5);
    chk("t6_single", 32'(got_m[4]), 32'({16'h80, 1'b1, 1'b1}));
    chk("end_overflow", 32'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
